// File: rtl/control_sequencer.sv
// Hardwired control sequencer for the fetch / ALU / branch / halt datapath.
// Optional build macro MEM_WAIT_EN: T1 stalls on Mem_rdy; otherwise T1 is one cycle.
module control_sequencer (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  input  logic        Mem_rdy,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        MDRout,
  output logic        Cout,
  output logic        BAout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Rin,
  output logic        CONin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rout,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  ALU_op,
  output logic        Run
);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // RST is the T0-pending encoding held while Resetn is low.
  typedef enum logic [3:0] {
    T0   = 4'd0,
    T1   = 4'd1,
    T2   = 4'd2,
    T3   = 4'd3,
    T4   = 4'd4,
    T5   = 4'd5,
    T6   = 4'd6,
    HALT = 4'd7,
    RST  = 4'd15
  } state_e;

  typedef struct packed {
    logic       pc_out;
    logic       zlo_out;
    logic       zhi_out;
    logic       mdr_out;
    logic       c_out;
    logic       ba_out;
    logic       mar_in;
    logic       z_in;
    logic       pc_in;
    logic       mdr_in;
    logic       ir_in;
    logic       y_in;
    logic       r_in;
    logic       con_in;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       r_out;
    logic       inc_pc;
    logic       read;
    logic       write;
    logic       run;
    logic [4:0] alu_op;
  } ctl_t;

  state_e     state_q, state_d;
  ctl_t       ctl_q, ctl_d;
  logic [4:0] opcode;
  logic       is_alu, is_br;
  logic       unused_ok;

  assign opcode    = IR[31:27];
  assign is_alu    = (opcode == OP_ADD) || (opcode == OP_SUB);
  assign is_br     = (opcode == OP_BR);
  assign unused_ok = ^{IR[26:0], Mem_rdy};

  always_comb begin
    state_d = state_q;
    case (state_q)
      RST:  state_d = T0;
      T0:   state_d = Stop ? HALT : T1;
`ifdef MEM_WAIT_EN
      T1:   state_d = Mem_rdy ? T2 : T1;
`else
      T1:   state_d = T2;
`endif
      T2: begin
        if (is_alu || is_br)        state_d = T3;
        else if (opcode == OP_HALT) state_d = HALT;
        else                        state_d = T0;
      end
      T3:   state_d = T4;
      T4:   state_d = T5;
      T5:   state_d = is_br ? T6 : T0;
      T6:   state_d = T0;
      HALT: state_d = HALT;
      default: state_d = T0;
    endcase
  end

  // Outputs are decoded from the state being entered so they appear registered
  // for exactly the cycle spent in that state.
  always_comb begin
    ctl_d     = '0;
    ctl_d.run = (state_d != HALT);
    case (state_d)
      T0: begin
        ctl_d.pc_out = 1'b1;
        ctl_d.mar_in = 1'b1;
        ctl_d.inc_pc = 1'b1;
        ctl_d.z_in   = 1'b1;
        ctl_d.alu_op = OP_ADD;
      end
      T1: begin
        ctl_d.read   = 1'b1;
        ctl_d.mdr_in = 1'b1;
        // PC update only once, even if T1 stalls on memory.
        if (state_q != T1) begin
          ctl_d.zlo_out = 1'b1;
          ctl_d.pc_in   = 1'b1;
        end
      end
      T2: begin
        ctl_d.mdr_out = 1'b1;
        ctl_d.ir_in   = 1'b1;
      end
      T3: begin
        ctl_d.r_out = 1'b1;
        if (is_br) begin
          ctl_d.gra    = 1'b1;
          ctl_d.con_in = 1'b1;
        end else begin
          ctl_d.grb  = 1'b1;
          ctl_d.y_in = 1'b1;
        end
      end
      T4: begin
        if (is_br) begin
          ctl_d.pc_out = 1'b1;
          ctl_d.y_in   = 1'b1;
        end else begin
          ctl_d.grc    = 1'b1;
          ctl_d.r_out  = 1'b1;
          ctl_d.z_in   = 1'b1;
          ctl_d.alu_op = opcode;
        end
      end
      T5: begin
        if (is_br) begin
          ctl_d.c_out  = 1'b1;
          ctl_d.z_in   = 1'b1;
          ctl_d.alu_op = OP_ADD;
        end else begin
          ctl_d.zlo_out = 1'b1;
          ctl_d.gra     = 1'b1;
          ctl_d.r_in    = 1'b1;
        end
      end
      T6: begin
        ctl_d.zlo_out = 1'b1;
        ctl_d.pc_in   = CON_FF;
      end
      default: ctl_d = '0;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= RST;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
    end
  end

  assign PCout    = ctl_q.pc_out;
  assign Zlowout  = ctl_q.zlo_out;
  assign Zhighout = ctl_q.zhi_out;
  assign MDRout   = ctl_q.mdr_out;
  assign Cout     = ctl_q.c_out;
  assign BAout    = ctl_q.ba_out;
  assign MARin    = ctl_q.mar_in;
  assign Zin      = ctl_q.z_in;
  assign PCin     = ctl_q.pc_in;
  assign MDRin    = ctl_q.mdr_in;
  assign IRin     = ctl_q.ir_in;
  assign Yin      = ctl_q.y_in;
  assign Rin      = ctl_q.r_in;
  assign CONin    = ctl_q.con_in;
  assign Gra      = ctl_q.gra;
  assign Grb      = ctl_q.grb;
  assign Grc      = ctl_q.grc;
  assign Rout     = ctl_q.r_out;
  assign IncPC    = ctl_q.inc_pc;
  assign Read     = ctl_q.read;
  assign Write    = ctl_q.write;
  assign ALU_op   = ctl_q.alu_op;
  assign Run      = ctl_q.run;

  a_bus_onehot: assert property (@(posedge Clock) disable iff (!Resetn)
    $onehot0({PCout, Zlowout, Zhighout, MDRout, Cout, BAout}));

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: fixed vector table, sequence-list reference model, corner cases.
module tb_control_sequencer;
  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic [31:0] IR = '0;
  logic        CON_FF = 1'b0, Stop = 1'b0, Mem_rdy = 1'b0;
  logic PCout, Zlowout, Zhighout, MDRout, Cout, BAout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, Rin, CONin;
  logic Gra, Grb, Grc, Rout, IncPC, Read, Write, Run;
  logic [4:0] ALU_op;

  always #5 Clock = ~Clock;

  control_sequencer dut (
    .Clock(Clock), .Resetn(Resetn), .IR(IR), .CON_FF(CON_FF), .Stop(Stop), .Mem_rdy(Mem_rdy),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout), .Cout(Cout),
    .BAout(BAout), .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .Rin(Rin), .CONin(CONin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rout(Rout),
    .IncPC(IncPC), .Read(Read), .Write(Write), .ALU_op(ALU_op), .Run(Run)
  );

  logic [26:0] obs;
  assign obs = {Run, ALU_op, PCout, Zlowout, Zhighout, MDRout, Cout, BAout, MARin, Zin, PCin,
                MDRin, IRin, Yin, Rin, CONin, Gra, Grb, Grc, Rout, IncPC, Read, Write};

  localparam logic [26:0] M_READ  = 27'd1 << 1,  M_INCPC = 27'd1 << 2,  M_ROUT  = 27'd1 << 3;
  localparam logic [26:0] M_GRC   = 27'd1 << 4,  M_GRB   = 27'd1 << 5,  M_GRA   = 27'd1 << 6;
  localparam logic [26:0] M_CONIN = 27'd1 << 7,  M_RIN   = 27'd1 << 8,  M_YIN   = 27'd1 << 9;
  localparam logic [26:0] M_IRIN  = 27'd1 << 10, M_MDRIN = 27'd1 << 11, M_PCIN  = 27'd1 << 12;
  localparam logic [26:0] M_ZIN   = 27'd1 << 13, M_MARIN = 27'd1 << 14, M_COUT  = 27'd1 << 16;
  localparam logic [26:0] M_MDROUT= 27'd1 << 17, M_ZLOW  = 27'd1 << 19, M_PCOUT = 27'd1 << 20;
  localparam logic [26:0] M_RUN   = 27'd1 << 26;
  localparam logic [26:0] A_ADD   = 27'd3 << 21;

  localparam logic [26:0] V_FETCH = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN | A_ADD;
  localparam logic [26:0] V_T1F   = M_RUN | M_ZLOW | M_PCIN | M_READ | M_MDRIN;
  localparam logic [26:0] V_T1W   = M_RUN | M_READ | M_MDRIN;
  localparam logic [26:0] V_T2    = M_RUN | M_MDROUT | M_IRIN;
  localparam logic [26:0] V_A3    = M_RUN | M_GRB | M_ROUT | M_YIN;
  localparam logic [26:0] V_A4    = M_RUN | M_GRC | M_ROUT | M_ZIN;
  localparam logic [26:0] V_A5    = M_RUN | M_ZLOW | M_GRA | M_RIN;
  localparam logic [26:0] V_B3    = M_RUN | M_GRA | M_ROUT | M_CONIN;
  localparam logic [26:0] V_B4    = M_RUN | M_PCOUT | M_YIN;
  localparam logic [26:0] V_B5    = M_RUN | M_COUT | M_ZIN | A_ADD;
  localparam logic [26:0] V_B6    = M_RUN | M_ZLOW;

  int n_tests = 0, n_fail = 0;

  task automatic chk_v(input string name, input logic [26:0] act, input logic [26:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: the per-cycle list of control steps an instruction should produce,
  // with the Stop/Mem_rdy values to drive during each of those cycles.
  logic [26:0] exp_q[$];
  bit          stop_q[$];
  bit          rdy_q[$];

  function automatic void push(input logic [26:0] v, input bit st, input bit rd);
    exp_q.push_back(v);
    stop_q.push_back(st);
    rdy_q.push_back(rd);
  endfunction

  function automatic bit nz(input bit noise);
    return noise ? bit'($urandom_range(0, 1)) : 1'b0;
  endfunction

  function automatic void build(input logic [31:0] ir, input bit con, input bit stop0,
                                input int waits, input bit noise);
    logic [4:0] op;
    op = ir[31:27];
    exp_q.delete(); stop_q.delete(); rdy_q.delete();
    push(V_FETCH, stop0, nz(noise));
    if (stop0) begin
      repeat (3) push('0, nz(noise), nz(noise));
      return;
    end
`ifdef MEM_WAIT_EN
    for (int w = 0; w <= waits; w++) push((w == 0) ? V_T1F : V_T1W, nz(noise), w == waits);
`else
    push(V_T1F, nz(noise), waits == 0);
`endif
    push(V_T2, nz(noise), nz(noise));
    case (op)
      5'b00011, 5'b00100: begin
        push(V_A3, nz(noise), nz(noise));
        push(V_A4 | ({22'd0, op} << 21), nz(noise), nz(noise));
        push(V_A5, nz(noise), nz(noise));
      end
      5'b10010: begin
        push(V_B3, nz(noise), nz(noise));
        push(V_B4, nz(noise), nz(noise));
        push(V_B5, nz(noise), nz(noise));
        push(con ? (V_B6 | M_PCIN) : V_B6, nz(noise), nz(noise));
      end
      5'b11011: repeat (3) push('0, nz(noise), nz(noise));
      default: ;
    endcase
  endfunction

  // Entered at the falling edge where T0 is visible; leaves at the next instruction's T0.
  task automatic run_instr(input string name, input logic [31:0] ir, input bit con);
    IR = ir;
    CON_FF = con;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge Clock);
      chk_v($sformatf("%s_c%0d", name, i), obs, exp_q[i]);
      Stop = stop_q[i];
      Mem_rdy = rdy_q[i];
    end
    @(negedge Clock);
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    Stop = 1'b0;
    #1 chk_v("rst_async", obs, '0);
    @(negedge Clock);
    chk_v("rst_hold", obs, '0);
    Resetn = 1'b1;
    @(negedge Clock);
  endtask

  typedef struct {
    logic [31:0] ir;
    bit          con;
    int          len;
    logic [26:0] last;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [31:0] ir;
    logic [4:0]  op;
    tbl[0] = '{32'h1800_0000, 1'b0, 6, V_A5};
    tbl[1] = '{32'h2000_1234, 1'b1, 6, V_A5};
    tbl[2] = '{32'h9000_0005, 1'b1, 7, V_B6 | M_PCIN};
    tbl[3] = '{32'h9000_0005, 1'b0, 7, V_B6};
    tbl[4] = '{32'h0000_0000, 1'b0, 3, V_T2};
    tbl[5] = '{32'hF800_0000, 1'b1, 3, V_T2};

    repeat (3) begin
      @(negedge Clock);
      chk_v("reset_low", obs, '0);
    end
    Resetn = 1'b1;
    @(negedge Clock);
    chk_v("fetch_after_reset", obs, V_FETCH);

    for (int k = 0; k < 6; k++) begin
      int cnt;
      logic [26:0] last;
      IR = tbl[k].ir; CON_FF = tbl[k].con; Stop = 1'b0; Mem_rdy = 1'b1;
      chk_v($sformatf("tbl%0d_t0", k), obs, V_FETCH);
      cnt = 1;
      last = obs;
      for (int c = 0; c < 20; c++) begin
        @(negedge Clock);
        if (obs == V_FETCH) break;
        cnt++;
        last = obs;
      end
      chk_i($sformatf("tbl%0d_len", k), cnt, tbl[k].len);
      chk_v($sformatf("tbl%0d_last", k), last, tbl[k].last);
    end

    // Reset pulse during T4 of a branch must clear outputs without waiting for a clock.
    IR = 32'h9000_0005; CON_FF = 1'b1; Stop = 1'b0; Mem_rdy = 1'b1;
    repeat (4) @(negedge Clock);
    chk_v("midrst_t4", obs, V_B4);
    #1 Resetn = 1'b0;
    #1 chk_v("midrst_clear", obs, '0);
    #1 Resetn = 1'b1;
    @(negedge Clock);
    chk_v("midrst_restart", obs, V_FETCH);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: op = 5'b00011;
        1: op = 5'b00100;
        2: op = 5'b10010;
        default: begin
          op = 5'($urandom);
          while (op == 5'b00011 || op == 5'b00100 || op == 5'b10010 || op == 5'b11011)
            op = 5'($urandom);
        end
      endcase
      ir = {op, 27'($urandom)};
      build(ir, bit'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 3), 1'b1);
      run_instr($sformatf("rnd%0d", n), ir, CON_FF ^ CON_FF ^ bit'(exp_q[exp_q.size()-1][12]));
    end

    build(32'h1800_0000, 1'b0, 1'b0, 0, 1'b0);
    stop_q[4] = 1'b1;
    run_instr("stop_in_t4", 32'h1800_0000, 1'b0);

    build(32'h1800_0000, 1'b0, 1'b0, 4, 1'b0);
    run_instr("memwait", 32'h1800_0000, 1'b0);

    build(32'hD800_0000, 1'b0, 1'b0, 0, 1'b0);
    run_instr("halt_op", 32'hD800_0000, 1'b0);
    do_reset();

    build(32'h1800_0000, 1'b0, 1'b1, 0, 1'b0);
    run_instr("stop_t0", 32'h1800_0000, 1'b0);
    do_reset();

    build(32'h1800_0000, 1'b0, 1'b0, 0, 1'b0);
    run_instr("after_halt", 32'h1800_0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
- REQ-001: Clock  input  1  — system clock; all state changes on its rising edge.
- REQ-002: Resetn  input  1  — reset is asynchronous and active-low.
- REQ-003: IR  input  32  — instruction register from datapath; opcode = IR[31:27].
- REQ-004: CON_FF  input  1  — branch-condition flag from datapath CON logic.
- REQ-005: Stop  input  1  — halt request, sampled only in T0.
- REQ-006: Mem_rdy  input  1  — memory read complete; used only with MEM_WAIT_EN.
- REQ-007: PCout, Zlowout, Zhighout, MDRout, Cout, BAout  output  1 each — bus-source selects.
- REQ-008: MARin, Zin, PCin, MDRin, IRin, Yin, Rin, CONin  output  1 each — register load enables.
- REQ-009: Gra, Grb, Grc, Rout, IncPC, Read, Write  output  1 each — register-select and memory controls.
- REQ-010: ALU_op  output  5  — ALU operation code (00011 add, 00100 sub).
- REQ-011: Run  output  1  — 1 while sequencing, 0 in HALT.

Function
- REQ-012: States SHALL be T0, T1, T2, T3, T4, T5, T6 and HALT, encoded in a 4-bit registered state.
- REQ-013: All outputs SHALL be registered Moore outputs, decoded from next state and IR, asserted for exactly one Clock period per state.
- REQ-014: At most one bus-source output SHALL be 1 in any cycle.
- REQ-015: T0 (fetch) asserts PCout, MARin, IncPC, Zin and ALU_op=00011. Next state is T1, or HALT if Stop=1.
- REQ-016: T1 asserts Zlowout, PCin, Read, MDRin. Next state is T2.
- REQ-017: T2 asserts MDRout, IRin. Next state is T3 for opcodes 00011, 00100 and 10010.
  - Opcode 11011 (halt) goes to HALT.
  - Any other opcode is a NOP and returns to T0.
- REQ-018: ALU ops (00011 add, 00100 sub) sequence:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, ALU_op = opcode.
  - T5: Zlowout, Gra, Rin.
  - Next state is T0; T6 is unused for this class.
- REQ-019: Branch (10010) sequence:
  - T3: Gra, Rout, CONin.
  - T4: PCout, Yin.
  - T5: Cout, Zin, ALU_op=00011.
  - T6: Zlowout; PCin asserted only if CON_FF=1 during T6.
  - Next state is T0.
- REQ-020: CON_FF SHALL be sampled in the T6 decode, not earlier; a taken branch loads PC = PC+1+C (sign-extended IR[18:0] via Cout).
- REQ-021: In HALT all outputs SHALL be 0 and Run=0; HALT is left only by reset.
- REQ-022: Stop asserted outside T0 SHALL be ignored; the current instruction always completes.
- REQ-023: Write and BAout SHALL remain 0 for every supported opcode, and Zhighout SHALL remain 0.

Reset
- REQ-024: While Resetn=0, the state SHALL be T0-pending: all outputs are 0, Run=0, and ALU_op=00000.
- REQ-025: On the first rising Clock edge after Resetn deasserts, the T0 outputs SHALL be asserted and Run=1.
- REQ-026: Reset asserted mid-instruction SHALL abort it immediately and asynchronously; no partial register load completes after the assertion.

Configuration
- REQ-027: Macro MEM_WAIT_EN selects whether T1 waits for memory.
  - Defined: T1 holds, with Read and MDRin held high and Zlowout/PCin asserted only in the first T1 cycle, until Mem_rdy=1; it then advances to T2.
  - Undefined: Mem_rdy is ignored and T1 lasts exactly one cycle.

Verification
- REQ-028: Reset → fetch. Hold Resetn=0 for 3 cycles, then release → all outputs 0 during reset; PCout=MARin=IncPC=Zin=1 on the first edge after release.
- REQ-029: Add instruction. IR=0x18000000 (add) → states T0..T5 in 6 cycles; ALU_op=00011 with Zin in T4; Gra/Rin in T5; T0 follows.
- REQ-030: Taken branch. IR=0x90000005 (branch) with CON_FF=1 in T6 → PCin=1 with Zlowout in T6. Repeat with CON_FF=0 → PCin=0 in T6; 7 cycles total in both cases.
- REQ-031: Halt. IR opcode 11011 → HALT after T2, Run=0. Stop=1 in T0 → HALT after one cycle. Stop=1 during T4 → ignored.
- REQ-032: Reset mid-instruction. Pulse Resetn=0 during T4 of a branch → all outputs 0 within the same cycle; the sequence restarts at T0.
- REQ-033: MEM_WAIT_EN defined. Mem_rdy held low for 4 cycles → T1 lasts 5 cycles with Read=1 throughout and PCin only in the first; T2 follows.
